// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I front-end types and constants
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_HOLD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM with redirect
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  redirect_target;
    logic         capture;

    assign redirect_target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = imem_gnt ? ST_DRAIN : ST_REQ;
                end else if (imem_gnt) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    // An in-flight response belongs to the old path; drain it unless it is here now.
                    pc_next    = redirect_target;
                    state_next = imem_rvalid ? ST_REQ : ST_DRAIN;
                end else if (imem_rvalid) begin
                    capture    = 1'b1;
                    pc_next    = pc + 32'd4;
                    state_next = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) pc_next = redirect_target;
                if (imem_rvalid)    state_next = ST_REQ;
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = ST_REQ;
                end else if (instr_ready) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= PC_INIT;
            instruction <= NOP_INSTR;
            instr_pc    <= 32'h0000_0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (capture) begin
                instruction <= imem_rdata;
                instr_pc    <= pc;
            end
        end
    end

    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_HOLD) && !redirect_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_gnt, imem_rvalid, redirect_valid, instr_ready;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instruction, instr_pc;
    logic        hi_req, hi_valid;
    logic [31:0] hi_addr, hi_instruction, hi_instr_pc;

    int tests = 0;
    int fails = 0;

    // model: fetch pointer plus flags for an outstanding, possibly stale, request and a held word
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_idle, m_pending, m_stale, m_hold;

    bit          mem_busy;
    int          mem_timer;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(hi_valid), .instr_ready(instr_ready),
        .instruction(hi_instruction), .instr_pc(hi_instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0000_0000;
        m_idle    = 1'b1;
        m_pending = 1'b0;
        m_stale   = 1'b0;
        m_hold    = 1'b0;
        m_instr   = 32'h0000_0013;
        m_ipc     = 32'h0000_0000;
    endtask

    function automatic bit req_exp();
        return !m_idle && !m_pending && !m_hold;
    endfunction

    // caller is at a negedge; drive inputs, then compare the DUT against the model
    task automatic apply(input bit gnt, input bit rv, input logic [31:0] rd,
                         input bit redir, input logic [31:0] rpc, input bit rdy);
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
        check("imem_req", {31'd0, imem_req}, {31'd0, req_exp()});
        check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (req_exp()) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_hold && !redir});
        if (m_hold) begin
            check("instruction", instruction, m_instr);
            check("instr_pc", instr_pc, m_ipc);
        end
    endtask

    task automatic tick();
        bit req_now;
        @(posedge clk);
        if (rst_n) begin
            if (m_idle) begin
                m_idle = 1'b0;
            end else begin
                req_now = req_exp();
                if (m_hold && (redirect_valid || instr_ready)) m_hold = 1'b0;
                if (m_pending && imem_rvalid) begin
                    if (!m_stale && !redirect_valid) begin
                        m_hold  = 1'b1;
                        m_instr = imem_rdata;
                        m_ipc   = m_pc;
                        m_pc    = m_pc + 32'd4;
                    end
                    m_pending = 1'b0;
                end else if (m_pending && redirect_valid) begin
                    m_stale = 1'b1;
                end
                if (req_now && imem_gnt) begin
                    m_pending = 1'b1;
                    m_stale   = redirect_valid;
                end
                if (redirect_valid) m_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instruction", instruction, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n     = 1'b1;
        mem_busy  = 1'b0;
        mem_timer = 0;
        model_reset();
    endtask

    initial begin
        bit          g, rv, rd_, rdy, granted;
        logic [31:0] data, tgt;

        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        instr_ready    = 1'b0;
        model_reset();
        mem_busy  = 1'b0;
        mem_timer = 0;
        @(negedge clk);
        do_reset();
        check("hi_rst_instruction", hi_instruction, 32'h0000_0013);

        // first fetch with gnt immediately and rvalid one cycle later
        apply(0, 0, 0, 0, 0, 0);
        check("idle_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        apply(1, 0, 0, 0, 0, 0);
        check("first_addr", imem_addr, 32'h0000_0000);
        check("hi_first_addr", hi_addr, 32'hFFFF_FFFC);
        tick();
        apply(0, 1, 32'h0050_0093, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 1);
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_instr", instruction, 32'h0050_0093);
        check("first_ipc", instr_pc, 32'h0000_0000);
        check("hi_first_ipc", hi_instr_pc, 32'hFFFF_FFFC);
        tick();
        apply(1, 0, 0, 0, 0, 0);
        check("second_addr", imem_addr, 32'h0000_0004);
        check("hi_second_addr", hi_addr, 32'h0000_0000);
        tick();

        // redirect while waiting, late response must be dropped
        apply(0, 0, 0, 1, 32'h0000_0103, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0);
        tick();
        apply(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check("drain_no_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        apply(1, 0, 0, 0, 0, 0);
        check("redirect_addr", imem_addr, 32'h0000_0100);
        check("redirect_req", {31'd0, imem_req}, 32'd1);
        tick();
        apply(0, 1, 32'h00A0_0113, 0, 0, 0);
        tick();

        // stall in HOLD
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            check("hold_instr", instruction, 32'h00A0_0113);
            check("hold_ipc", instr_pc, 32'h0000_0100);
            check("hold_no_req", {31'd0, imem_req}, 32'd0);
            tick();
        end

        // redirect beats instr_ready in HOLD
        apply(0, 0, 0, 1, 32'h0000_0200, 1);
        check("redir_ready_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        apply(1, 0, 0, 0, 0, 0);
        check("redir_ready_addr", imem_addr, 32'h0000_0200);
        tick();

        // reset during WAIT; memory side is reset too
        do_reset();
        apply(0, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0);
        check("post_rst_addr", imem_addr, 32'h0000_0000);
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        tick();

        // randomized traffic against the model with a single-outstanding memory
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                continue;
            end
            g    = ($urandom_range(0, 2) != 0);
            rv   = mem_busy && (mem_timer == 0);
            data = $urandom;
            rd_  = !m_idle && ($urandom_range(0, 7) == 0);
            tgt  = $urandom;
            rdy  = ($urandom_range(0, 2) != 0);
            granted = req_exp() && g;
            apply(g, rv, data, rd_, tgt, rdy);
            tick();
            if (rv) begin
                mem_busy = 1'b0;
            end else if (mem_busy && mem_timer > 0) begin
                mem_timer--;
            end
            if (granted) begin
                mem_busy  = 1'b1;
                mem_timer = $urandom_range(0, 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
